// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master that moves xfer_len words from a TX FIFO to an RX FIFO.
// Define SPI_XFER_CTRL_RX_STALL_EN to stall on a full RX FIFO instead of dropping.
module spi_xfer_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 go,
    input  logic                 abort,
    input  logic [2:0]           xfer_len,
    input  logic [DATAWIDTH-1:0] tx_dout,
    input  logic                 tx_empty,
    output logic                 tx_re_en,
    input  logic                 rx_full,
    output logic [DATAWIDTH-1:0] rx_din,
    output logic                 rx_wr_en,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 ss_n,
    output logic                 busy,
    output logic                 done,
    output logic                 rx_ovf
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] STORE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATAWIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATAWIDTH - 1);

    logic [2:0]           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 sclk_q, sclk_d;
    logic                 ovf_q, ovf_d;
    logic [DATAWIDTH-1:0] txsh_q, txsh_d;
    logic [DATAWIDTH-1:0] rxsh_q, rxsh_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        ovf_d   = ovf_q;
        txsh_d  = txsh_q;
        rxsh_d  = rxsh_q;
        if (abort) begin
            state_d = IDLE;
            sclk_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        if (xfer_len != 3'd0) begin
                            cnt_d   = xfer_len;
                            ovf_d   = 1'b0;
                            state_d = LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                LOAD: begin
                    if (!tx_empty) begin
                        txsh_d  = tx_dout;
                        div_d   = '0;
                        bit_d   = '0;
                        sclk_d  = 1'b0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        sclk_d = !sclk_q;
                        // rising edge samples, falling edge shifts
                        if (!sclk_q) begin
                            rxsh_d = {rxsh_q[DATAWIDTH-2:0], miso};
                        end else begin
                            txsh_d = txsh_q << 1;
                            bit_d  = bit_q + BIT_W'(1);
                            if (bit_q == BIT_LAST) begin
                                state_d = STORE;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                STORE: begin
                    if (!rx_full) begin
                        cnt_d   = cnt_q - 3'd1;
                        state_d = (cnt_q == 3'd1) ? DONE : LOAD;
                    end else begin
`ifdef SPI_XFER_CTRL_RX_STALL_EN
                        state_d = STORE;
`else
                        ovf_d   = 1'b1;
                        cnt_d   = cnt_q - 3'd1;
                        state_d = (cnt_q == 3'd1) ? DONE : LOAD;
`endif
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            ovf_q   <= 1'b0;
            txsh_q  <= '0;
            rxsh_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            ovf_q   <= ovf_d;
            txsh_q  <= txsh_d;
            rxsh_q  <= rxsh_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE) && !abort;
    assign ss_n     = !((state_q == LOAD) || (state_q == SHIFT) ||
                        (state_q == STORE));
    assign tx_re_en = (state_q == LOAD) && !tx_empty && !abort;
    assign rx_wr_en = (state_q == STORE) && !rx_full && !abort;
    assign sclk     = sclk_q;
    assign mosi     = (state_q == SHIFT) && txsh_q[DATAWIDTH-1];
    assign rx_din   = rxsh_q;
    assign rx_ovf   = ovf_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: FIFO and SPI-slave models with a byte-level scoreboard.
// Honours SPI_XFER_CTRL_RX_STALL_EN the same way as the design.
module tb_spi_xfer_ctrl;

    localparam int DW = 8;
    localparam int CD = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    xfer_len = 3'd0;
    logic [DW-1:0] tx_dout = '0;
    logic          tx_empty = 1'b1;
    logic          tx_re_en;
    logic          rx_full = 1'b0;
    logic [DW-1:0] rx_din;
    logic          rx_wr_en;
    logic          sclk;
    logic          mosi;
    logic          miso = 1'b0;
    logic          ss_n;
    logic          busy;
    logic          done;
    logic          rx_ovf;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DATAWIDTH(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rstn(rstn), .go(go), .abort(abort),
        .xfer_len(xfer_len), .tx_dout(tx_dout), .tx_empty(tx_empty),
        .tx_re_en(tx_re_en), .rx_full(rx_full), .rx_din(rx_din),
        .rx_wr_en(rx_wr_en), .sclk(sclk), .mosi(mosi), .miso(miso),
        .ss_n(ss_n), .busy(busy), .done(done), .rx_ovf(rx_ovf)
    );

    logic [DW-1:0] txq[$];
    logic [DW-1:0] sentq[$];
    logic [DW-1:0] misoq[$];
    logic [DW-1:0] rxq[$];
    logic          mosiq[$];
    int            pop_cyc[$];
    int            wr_cyc[$];
    int            done_cyc[$];
    int cyc, rises, n_pop, n_wr, n_done;
    int hold, full_cnt, ss_low, ssviol, wait_viol, full_viol, empty_viol;
    bit pop_pend, sclk_prev, hold_arm, full_arm, hold_act;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mbyte(input int i);
        logic [DW-1:0] r;
        r = '0;
        for (int b = 0; b < DW; b++) begin
            if (i * DW + b < mosiq.size())
                r = {r[DW-2:0], mosiq[i*DW+b]};
            else
                r = {r[DW-2:0], 1'bx};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_pend) begin
            void'(txq.pop_front());
            pop_pend = 1'b0;
        end
        hold_act = (hold > 0);
        tx_empty = (txq.size() == 0) || hold_act;
        tx_dout  = (txq.size() != 0) ? txq[0] : '0;
        rx_full  = (full_cnt > 0);
        if (rises / DW < misoq.size())
            miso = misoq[rises/DW][DW-1-(rises%DW)];
        else
            miso = 1'b0;
        @(negedge clk);
        cyc++;
        if (hold > 0) hold--;
        if (full_cnt > 0) full_cnt--;
        if (tx_re_en) begin
            n_pop++;
            pop_pend = 1'b1;
            pop_cyc.push_back(cyc);
            if (tx_empty) empty_viol++;
        end
        if (rx_wr_en) begin
            n_wr++;
            rxq.push_back(rx_din);
            wr_cyc.push_back(cyc);
            if (rx_full) full_viol++;
            if (hold_arm) begin hold = 10; hold_arm = 1'b0; end
            if (full_arm) begin full_cnt = 40; full_arm = 1'b0; end
        end
        if (done) begin
            n_done++;
            done_cyc.push_back(cyc);
        end
        if (sclk && !sclk_prev) begin
            mosiq.push_back(mosi);
            rises++;
        end
        sclk_prev = sclk;
        if (!ss_n) ss_low++;
        if (busy && !done && ss_n) ssviol++;
        if (hold_act && (sclk || ss_n || !busy)) wait_viol++;
    endtask

    task automatic clear_mon();
        txq.delete(); sentq.delete(); misoq.delete(); rxq.delete();
        mosiq.delete(); pop_cyc.delete(); wr_cyc.delete(); done_cyc.delete();
        rises = 0; n_pop = 0; n_wr = 0; n_done = 0;
        hold = 0; full_cnt = 0; ss_low = 0; ssviol = 0;
        wait_viol = 0; full_viol = 0; empty_viol = 0;
        pop_pend = 1'b0; hold_arm = 1'b0; full_arm = 1'b0;
        sclk_prev = sclk;
    endtask

    task automatic load_rand(input int len);
        logic [DW-1:0] v;
        for (int i = 0; i < len; i++) begin
            v = DW'($urandom);
            txq.push_back(v);
            sentq.push_back(v);
            misoq.push_back(DW'($urandom));
        end
    endtask

    task automatic run(input int len, input int budget);
        int k;
        k = 0;
        go = 1'b1;
        xfer_len = 3'(len);
        step();
        go = 1'b0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        chk("xfer_finished", 64'(n_done > 0), 64'd1);
        step();
    endtask

    task automatic chk_data(input string tag, input int len);
        chk({tag, "_mosi_bits"}, 64'(mosiq.size()), 64'(len * DW));
        chk({tag, "_rx_count"}, 64'(rxq.size()), 64'(len));
        for (int i = 0; i < len; i++) begin
            chk({tag, "_mosi"}, 64'(mbyte(i)), 64'(sentq[i]));
            if (i < rxq.size())
                chk({tag, "_rx"}, 64'(rxq[i]), 64'(misoq[i]));
        end
    endtask

    initial begin
        clear_mon();
        cyc = 0;
        repeat (3) step();
        chk("reset_outputs",
            64'({sclk, mosi, ss_n, busy, done, rx_ovf, tx_re_en, rx_wr_en}),
            64'b0010_0000);
        chk("reset_rx_din", 64'(rx_din), 64'd0);
        rstn = 1'b1;
        repeat (2) step();

        // single byte, fixed pattern
        clear_mon();
        txq.push_back(8'hA5); sentq.push_back(8'hA5); misoq.push_back(8'h3C);
        run(1, 200);
        chk_data("basic", 1);
        chk("basic_pops", 64'(n_pop), 64'd1);
        chk("basic_writes", 64'(n_wr), 64'd1);
        chk("basic_done", 64'(n_done), 64'd1);
        if (pop_cyc.size() > 0 && wr_cyc.size() > 0)
            chk("basic_frame_len", 64'(wr_cyc[0] - pop_cyc[0]),
                64'(2 * CD * DW + 1));
        if (wr_cyc.size() > 0 && done_cyc.size() > 0)
            chk("basic_done_lat", 64'(done_cyc[0] - wr_cyc[0]), 64'd1);
        chk("basic_idle", 64'({busy, ss_n, sclk}), 64'b010);

        // four bytes back to back
        clear_mon();
        for (int i = 1; i <= 4; i++) begin
            txq.push_back(DW'(i)); sentq.push_back(DW'(i));
            misoq.push_back(DW'($urandom));
        end
        run(4, 400);
        chk_data("multi", 4);
        chk("multi_pops", 64'(n_pop), 64'd4);
        chk("multi_writes", 64'(n_wr), 64'd4);
        chk("multi_done", 64'(n_done), 64'd1);
        chk("multi_ss_low", 64'(ssviol), 64'd0);

        // random lengths and data
        repeat (4) begin
            int len;
            len = int'($urandom_range(1, 7));
            clear_mon();
            load_rand(len);
            run(len, 40 * len + 40);
            chk_data("rand", len);
            chk("rand_ovf", 64'(rx_ovf), 64'd0);
            chk("rand_strobe_ok", 64'(empty_viol + full_viol), 64'd0);
        end

        // TX underflow between bytes
        clear_mon();
        load_rand(2);
        hold_arm = 1'b1;
        run(2, 200);
        chk_data("txwait", 2);
        chk("txwait_hold", 64'(wait_viol), 64'd0);
        if (pop_cyc.size() > 1 && wr_cyc.size() > 0)
            chk("txwait_gap", 64'(pop_cyc[1] - wr_cyc[0]), 64'd11);
        chk("txwait_empty_pop", 64'(empty_viol), 64'd0);

        // RX full at the second store
        clear_mon();
        load_rand(2);
        full_arm = 1'b1;
        run(2, 300);
        chk("rxfull_no_wr_full", 64'(full_viol), 64'd0);
        chk("rxfull_done", 64'(n_done), 64'd1);
`ifdef SPI_XFER_CTRL_RX_STALL_EN
        chk("rxfull_writes", 64'(n_wr), 64'd2);
        chk("rxfull_ovf", 64'(rx_ovf), 64'd0);
        if (wr_cyc.size() > 1)
            chk("rxfull_stall_gap", 64'(wr_cyc[1] - wr_cyc[0]), 64'd41);
        if (rxq.size() > 1)
            chk("rxfull_data", 64'(rxq[1]), 64'(misoq[1]));
`else
        chk("rxfull_writes", 64'(n_wr), 64'd1);
        chk("rxfull_ovf", 64'(rx_ovf), 64'd1);
        if (rxq.size() > 0)
            chk("rxfull_data", 64'(rxq[0]), 64'(misoq[0]));
`endif
        repeat (10) step();

        // abort in the middle of a frame
        clear_mon();
        load_rand(3);
        go = 1'b1; xfer_len = 3'd3;
        step();
        go = 1'b0;
        repeat (20) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("abort_idle", 64'({ss_n, busy, sclk}), 64'b100);
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_no_wr", 64'(n_wr), 64'd0);
        chk("abort_pops", 64'(n_pop), 64'd1);
        clear_mon();
        load_rand(1);
        run(1, 200);
        chk_data("after_abort", 1);
        chk("after_abort_ovf", 64'(rx_ovf), 64'd0);

        // reset in the middle of a frame
        clear_mon();
        load_rand(2);
        go = 1'b1; xfer_len = 3'd2;
        step();
        go = 1'b0;
        repeat (20) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async",
            64'({ss_n, busy, sclk, tx_re_en, rx_wr_en, done}), 64'b100000);
        repeat (2) step();
        chk("rst_no_done_wr", 64'(n_done + n_wr), 64'd0);
        rstn = 1'b1;
        step();
        clear_mon();
        load_rand(1);
        run(1, 200);
        chk_data("after_rst", 1);

        // abort and go together in idle
        clear_mon();
        load_rand(1);
        go = 1'b1; abort = 1'b1; xfer_len = 3'd1;
        step();
        go = 1'b0; abort = 1'b0;
        chk("abort_go_idle", 64'({busy, ss_n}), 64'b01);
        step();
        chk("abort_go_nopop", 64'(n_pop + n_done), 64'd0);

        // zero-length transfer
        clear_mon();
        begin
            int c0;
            c0 = cyc;
            run(0, 5);
            if (done_cyc.size() > 0)
                chk("len0_latency", 64'(done_cyc[0] - c0 <= 2), 64'd1);
        end
        chk("len0_done", 64'(n_done), 64'd1);
        chk("len0_strobes", 64'(n_pop + n_wr), 64'd0);
        chk("len0_ss_high", 64'(ss_low), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
